uart_rx_router: RTL and testbench
=================================

# uart_rx_router

Parametrised receive-side router between the UART byte core and the CPU/loader. Buffers normal-mode bytes in a configurable first-word-fall-through (FWFT) FIFO for the CPU. Detects the program-load start sequence MAGIC0, MAGIC1 with a timing-window check, then steers bytes to a dedicated program channel with backpressure. Leaves program mode on the END0, END1 pair or on an optional idle timeout.

## Interface
- CLOCK_HZ, 27_000_000: clock frequency.
- DATA_BITS, 8: byte width.
- FIFO_DEPTH, 4: CPU RX FIFO depth; must be a power of 2, ≥2.
- GAP_MIN_US, 200: minimum MAGIC0→MAGIC1 gap.
- GAP_MAX_US, 20000: maximum MAGIC0→MAGIC1 gap.
- PROG_TIMEOUT_MS, 0: program-mode idle timeout; 0 disables it.
- MAGIC0 / MAGIC1, 8'h55 / 8'hAA: start pair.
- END0 / END1, 8'h7F / 8'hFF: end pair.

Ports (one clock; reset is synchronous and active-high, ports named `clk` and `rst`):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  DATA_BITS  byte from UART core
- in_valid  in  1  UART core holds a byte
- in_ready  out  1  byte consumed this cycle when in_valid & in_ready (drives UART core rd)
- rx_data  out  DATA_BITS  FIFO head (FWFT)
- rx_full  out  1  FIFO non-empty
- rd  in  1  pop FIFO head
- rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- prog_data  out  DATA_BITS  program byte
- prog_valid  out  1  prog_data valid
- prog_ready  in  1  loader accepts prog_data
- prog_recv  out  1  program mode active
- prog_bytes  out  16  bytes accepted in current program session, saturating at 16'hFFFF
- prog_timeout  out  1  sticky: last session ended by timeout

## Operation

Derived cycle counts use 64-bit arithmetic:
- GMIN = CLOCK_HZ*GAP_MIN_US/1e6
- GMAX = CLOCK_HZ*GAP_MAX_US/1e6
- TOUT = CLOCK_HZ*PROG_TIMEOUT_MS/1e3

Two states: NORMAL and PROG; reset enters NORMAL. The first-word-fall-through (FWFT) FIFO shows its head on rx_data without a read.

NORMAL:
- A one-byte hold stage sits ahead of the FIFO.
- in_ready = ~hold_full | start.
- Gap timer:
  - Cleared when MAGIC0 is captured into hold.
  - Increments while hold contains MAGIC0.
  - Saturates at GMAX+1.
- Release of hold into the FIFO happens when the FIFO is not full (registered full, so a same-cycle pop does not free a slot) and one of the following holds:
  - hold ≠ MAGIC0;
  - timer > GMAX;
  - in_valid & in_data ≠ MAGIC1;
  - in_valid & in_data = MAGIC1 & timer < GMIN.
- A release and a new capture may occur in the same cycle.
- start = hold_full & hold = MAGIC0 & in_valid & in_data = MAGIC1 & GMIN ≤ timer ≤ GMAX. On start:
  - MAGIC1 is consumed.
  - Hold is discarded.
  - FIFO is flushed.
  - prog_bytes ← 0 and prog_timeout ← 0.
  - State → PROG.
- rd while FIFO is empty: ignored.

PROG:
- Single output register drives the program channel; in_ready = ~prog_valid | prog_ready.
- Each accepted byte loads prog_data and increments prog_bytes.
- END0, END1 are forwarded like any other byte.
- Exit on END1 accepted when the previous accepted byte was END0: state → NORMAL after the END1 byte is registered; prog_valid drains normally.
- Timeout: if TOUT > 0 and no byte is accepted for TOUT consecutive cycles, state → NORMAL and prog_timeout ← 1.
- FIFO remains poppable; no bytes enter it.
- The END0-seen flag clears on any non-END0 byte and on entry.

Reset mid-operation: all state cleared, in-flight bytes dropped.

## Timing
- Reset values:
  - rx_data 0, rx_full 0, rx_level 0
  - prog_data 0, prog_valid 0, prog_recv 0, prog_bytes 0, prog_timeout 0
  - in_ready 1 (after reset, since hold is empty)
- in_ready is combinational from in_valid and in_data (the start check) plus registered state.
- NORMAL latency for a non-MAGIC0 byte:
  - accepted at edge N → in hold at N;
  - pushed at edge N+1 (FIFO not full);
  - rx_full high from N+1.
- rx_data/rx_full/rx_level update the edge after rd.
- prog_recv rises the edge that consumes MAGIC1 and falls the edge that accepts END1 or hits timeout.
- The first PROG byte may be accepted the cycle after start.
- prog_valid rises the edge after acceptance and holds until prog_valid & prog_ready.

## Test plan
Bench configuration: CLOCK_HZ=1_000_000 (GMIN=200, GMAX=20000), FIFO_DEPTH=4.

1. Send 0x41, 0x42, 0x43 with no rd → rx_level=3, rx_data=0x41; three rd pulses → 0x42, 0x43, then rx_full=0.
2. Send 6 bytes with no rd → rx_level=4, hold full, in_ready=0 with the 6th pending; one rd → 5th enters FIFO, 6th accepted.
3. Send 0x55, wait 1000 cycles, send 0xAA → prog_recv=1 next edge, FIFO flushed (rx_full=0), neither byte in FIFO.
4. Send 0x55 then 0xAA 50 cycles later → FIFO holds 0x55, 0xAA, prog_recv=0. Separately, send lone 0x55 → released to FIFO at timer=20001.
5. In PROG, send 0x01, 0x7F, 0xFF with prog_ready=1 → prog channel sees 0x01, 0x7F, 0xFF, prog_bytes=3, prog_recv=0 after 0xFF. With prog_ready=0 and prog_valid=1 → in_ready=0.
6. PROG_TIMEOUT_MS=1, enter PROG, idle 1000 cycles → prog_recv=0, prog_timeout=1. Assert rst mid-PROG → all outputs at reset values next edge.

Source files
------------

// File: rtl/uart_rx_router.sv
// uart_rx_router: receive-side router between the UART byte core and the CPU/loader.
//
// Normal mode buffers received bytes in a first-word-fall-through FIFO for the CPU.
// The start pair MAGIC0, MAGIC1 switches to program mode, but only when the gap
// between the two bytes falls inside a time window. In program mode, bytes go to a
// single-register program channel with backpressure. Program mode ends on the
// END0, END1 pair, or on an optional idle timeout.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/in_valid     byte offered by the UART core
//   in_ready             byte consumed this cycle when in_valid & in_ready
//   rx_data/rx_full      FIFO head (FWFT) and non-empty flag
//   rd                   pop FIFO head (ignored when empty)
//   rx_level             FIFO occupancy
//   prog_data/valid      program byte channel, prog_ready is the loader's accept
//   prog_recv            program mode active
//   prog_bytes           bytes accepted this session, saturating
//   prog_timeout         sticky: last session ended by idle timeout
module uart_rx_router #(
  parameter int unsigned          CLOCK_HZ        = 27_000_000,
  parameter int unsigned          DATA_BITS       = 8,
  parameter int unsigned          FIFO_DEPTH      = 4,
  parameter int unsigned          GAP_MIN_US      = 200,
  parameter int unsigned          GAP_MAX_US      = 20000,
  parameter int unsigned          PROG_TIMEOUT_MS = 0,
  parameter logic [DATA_BITS-1:0] MAGIC0          = 8'h55,
  parameter logic [DATA_BITS-1:0] MAGIC1          = 8'hAA,
  parameter logic [DATA_BITS-1:0] END0            = 8'h7F,
  parameter logic [DATA_BITS-1:0] END1            = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_full,
  input  logic                          rd,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [DATA_BITS-1:0]          prog_data,
  output logic                          prog_valid,
  input  logic                          prog_ready,
  output logic                          prog_recv,
  output logic [15:0]                   prog_bytes,
  output logic                          prog_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  // Cycle counts derived from time parameters in 64-bit arithmetic.
  localparam longint unsigned GMinL = (64'(CLOCK_HZ) * 64'(GAP_MIN_US)) / 64'd1_000_000;
  localparam longint unsigned GMaxL = (64'(CLOCK_HZ) * 64'(GAP_MAX_US)) / 64'd1_000_000;
  localparam longint unsigned ToutL = (64'(CLOCK_HZ) * 64'(PROG_TIMEOUT_MS)) / 64'd1_000;

  // Timer must hold GMAX+1 (its saturation value).
  localparam int unsigned TimerW = $clog2(GMaxL + 64'd2);
  localparam logic [TimerW-1:0] GMin   = TimerW'(GMinL);
  localparam logic [TimerW-1:0] GMax   = TimerW'(GMaxL);
  localparam logic [TimerW-1:0] GMaxP1 = TimerW'(GMaxL + 64'd1);

  // Idle counter only needs to reach TOUT-1; exit happens on the TOUT-th idle cycle.
  localparam bit          ToutEn = (ToutL != 64'd0);
  localparam int unsigned ToutW  = (ToutL > 64'd1) ? $clog2(ToutL) : 1;
  localparam logic [ToutW-1:0] ToutLast = ToutW'(ToutL - 64'd1);

  typedef enum logic {StNormal, StProg} state_e;

  state_e                 state_q;

  // Hold stage and gap timer
  logic [DATA_BITS-1:0]   hold_q;
  logic                   hold_full_q;
  logic [TimerW-1:0]      timer_q;

  // FIFO
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [LW-1:0]          count_q;

  // Program channel
  logic [DATA_BITS-1:0]   prog_data_q;
  logic                   prog_valid_q;
  logic [15:0]            prog_bytes_q;
  logic                   prog_timeout_q;
  logic                   end0_seen_q;
  logic [ToutW-1:0]       idle_q;

  // Decode
  logic is_prog;
  logic fifo_full;
  logic fifo_pop;
  logic hold_m0;
  logic in_m1;
  logic start;
  logic release_hold;
  logic accept;
  logic capture;
  logic prog_accept;
  logic prog_end;
  logic prog_to;

  always_comb begin
    is_prog   = (state_q == StProg);
    // Registered occupancy: a pop in this cycle does not free a slot until next cycle.
    fifo_full = (count_q == LW'(FIFO_DEPTH));
    fifo_pop  = rd & (count_q != '0);
    hold_m0   = hold_full_q & (hold_q == MAGIC0);
    in_m1     = in_valid & (in_data == MAGIC1);

    start = ~is_prog & hold_m0 & in_m1 & (timer_q >= GMin) & (timer_q <= GMax);

    // Hold is released unless it holds a MAGIC0 that may still pair with MAGIC1.
    release_hold = ~is_prog & hold_full_q & ~fifo_full &
                   ((hold_q != MAGIC0) |
                    (timer_q > GMax) |
                    (in_valid & (in_data != MAGIC1)) |
                    (in_m1 & (timer_q < GMin)));

    if (is_prog) begin
      in_ready = ~prog_valid_q | prog_ready;
    end else begin
      in_ready = ~hold_full_q | start;
    end

    accept      = in_valid & in_ready;
    capture     = accept & ~is_prog & ~start;
    prog_accept = accept & is_prog;
    prog_end    = prog_accept & end0_seen_q & (in_data == END1);
    prog_to     = is_prog & ToutEn & ~prog_accept & (idle_q == ToutLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StNormal;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      timer_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      prog_data_q    <= '0;
      prog_valid_q   <= 1'b0;
      prog_bytes_q   <= '0;
      prog_timeout_q <= 1'b0;
      end0_seen_q    <= 1'b0;
      idle_q         <= '0;
    end else begin
      // Hold stage: start discards the held MAGIC0.
      if (start) begin
        hold_full_q <= 1'b0;
      end else if (capture) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (release_hold) begin
        hold_full_q <= 1'b0;
      end

      if (capture && (in_data == MAGIC0)) begin
        timer_q <= '0;
      end else if (hold_m0 && (timer_q != GMaxP1)) begin
        timer_q <= timer_q + TimerW'(1);
      end

      // FIFO: start flushes it.
      if (start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (release_hold) begin
          mem_q[wr_ptr_q] <= hold_q;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (fifo_pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        case ({release_hold, fifo_pop})
          2'b10:   count_q <= count_q + LW'(1);
          2'b01:   count_q <= count_q - LW'(1);
          default: count_q <= count_q;
        endcase
      end

      // Mode FSM
      case (state_q)
        StNormal: begin
          if (start) begin
            state_q        <= StProg;
            prog_bytes_q   <= '0;
            prog_timeout_q <= 1'b0;
            end0_seen_q    <= 1'b0;
            idle_q         <= '0;
          end
        end
        StProg: begin
          if (prog_to) begin
            state_q        <= StNormal;
            prog_timeout_q <= 1'b1;
          end else if (prog_end) begin
            state_q <= StNormal;
          end
          if (prog_accept) begin
            idle_q <= '0;
          end else if (ToutEn) begin
            idle_q <= idle_q + ToutW'(1);
          end
        end
        default: state_q <= StNormal;
      endcase

      // Program output register; keeps draining after leaving program mode.
      if (prog_accept) begin
        prog_data_q  <= in_data;
        prog_valid_q <= 1'b1;
        end0_seen_q  <= (in_data == END0);
        if (prog_bytes_q != 16'hFFFF) begin
          prog_bytes_q <= prog_bytes_q + 16'd1;
        end
      end else if (prog_valid_q && prog_ready) begin
        prog_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data      = mem_q[rd_ptr_q];
  assign rx_full      = (count_q != '0);
  assign rx_level     = count_q;
  assign prog_data    = prog_data_q;
  assign prog_valid   = prog_valid_q;
  assign prog_recv    = is_prog;
  assign prog_bytes   = prog_bytes_q;
  assign prog_timeout = prog_timeout_q;

endmodule

// File: tb/tb_uart_rx_router.sv
// Directed testbench for uart_rx_router at CLOCK_HZ=1 MHz (GMIN=200, GMAX=20000).
// dut runs without a program timeout; dut_t runs with a 1 ms (1000 cycle) timeout.
module tb_uart_rx_router;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  rx_data;
  logic        rx_full;
  logic        rd;
  logic [2:0]  rx_level;
  logic [7:0]  prog_data;
  logic        prog_valid;
  logic        prog_ready;
  logic        prog_recv;
  logic [15:0] prog_bytes;
  logic        prog_timeout;

  logic        t_rst;
  logic [7:0]  t_in_data;
  logic        t_in_valid;
  logic        t_in_ready;
  logic [7:0]  t_rx_data;
  logic        t_rx_full;
  logic        t_rd;
  logic [2:0]  t_rx_level;
  logic [7:0]  t_prog_data;
  logic        t_prog_valid;
  logic        t_prog_ready;
  logic        t_prog_recv;
  logic [15:0] t_prog_bytes;
  logic        t_prog_timeout;

  int checks;
  int failures;

  logic [7:0] seen [$];

  uart_rx_router #(
    .CLOCK_HZ       (1_000_000),
    .FIFO_DEPTH     (4),
    .PROG_TIMEOUT_MS(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rx_data     (rx_data),
    .rx_full     (rx_full),
    .rd          (rd),
    .rx_level    (rx_level),
    .prog_data   (prog_data),
    .prog_valid  (prog_valid),
    .prog_ready  (prog_ready),
    .prog_recv   (prog_recv),
    .prog_bytes  (prog_bytes),
    .prog_timeout(prog_timeout)
  );

  uart_rx_router #(
    .CLOCK_HZ       (1_000_000),
    .FIFO_DEPTH     (4),
    .PROG_TIMEOUT_MS(1)
  ) dut_t (
    .clk         (clk),
    .rst         (t_rst),
    .in_data     (t_in_data),
    .in_valid    (t_in_valid),
    .in_ready    (t_in_ready),
    .rx_data     (t_rx_data),
    .rx_full     (t_rx_full),
    .rd          (t_rd),
    .rx_level    (t_rx_level),
    .prog_data   (t_prog_data),
    .prog_valid  (t_prog_valid),
    .prog_ready  (t_prog_ready),
    .prog_recv   (t_prog_recv),
    .prog_bytes  (t_prog_bytes),
    .prog_timeout(t_prog_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record program-channel handshakes mid-cycle.
  always @(negedge clk) begin
    if (prog_valid && prog_ready) seen.push_back(prog_data);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Offer a byte and hold it until accepted (bounded).
  task automatic send(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_accept byte=%02h in_ready=%0b required=1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic enter_prog();
    send(8'h55);
    tick(300);
    send(8'hAA);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%02h exp=00", rx_data); end
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL reset_rx_full got=%0b exp=0", rx_full); end
    checks++; if (rx_level !== 3'd0) begin failures++; $display("FAIL reset_rx_level got=%0d exp=0", rx_level); end
    checks++; if (prog_data !== 8'h00) begin failures++; $display("FAIL reset_prog_data got=%02h exp=00", prog_data); end
    checks++; if (prog_valid !== 1'b0) begin failures++; $display("FAIL reset_prog_valid got=%0b exp=0", prog_valid); end
    checks++; if (prog_recv !== 1'b0) begin failures++; $display("FAIL reset_prog_recv got=%0b exp=0", prog_recv); end
    checks++; if (prog_bytes !== 16'd0) begin failures++; $display("FAIL reset_prog_bytes got=%0d exp=0", prog_bytes); end
    checks++; if (prog_timeout !== 1'b0) begin failures++; $display("FAIL reset_prog_timeout got=%0b exp=0", prog_timeout); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_fifo_basic();
    do_reset();
    send(8'h41);
    send(8'h42);
    send(8'h43);
    tick(1);
    checks++; if (rx_level !== 3'd3) begin failures++; $display("FAIL basic_level got=%0d exp=3", rx_level); end
    checks++; if (rx_data !== 8'h41) begin failures++; $display("FAIL basic_head got=%02h exp=41", rx_data); end
    rd = 1'b1; tick(1); rd = 1'b0;
    checks++; if (rx_data !== 8'h42) begin failures++; $display("FAIL basic_pop1 got=%02h exp=42", rx_data); end
    rd = 1'b1; tick(1); rd = 1'b0;
    checks++; if (rx_data !== 8'h43) begin failures++; $display("FAIL basic_pop2 got=%02h exp=43", rx_data); end
    rd = 1'b1; tick(1); rd = 1'b0;
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL basic_empty got=%0b exp=0", rx_full); end
    // Pop on empty is ignored.
    rd = 1'b1; tick(1); rd = 1'b0;
    checks++; if (rx_level !== 3'd0) begin failures++; $display("FAIL basic_empty_pop got=%0d exp=0", rx_level); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp [5];
    exp = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
    in_data  = 8'h16;
    in_valid = 1'b1;
    tick(3);
    checks++; if (rx_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", rx_level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    rd = 1'b1; tick(1); rd = 1'b0;
    checks++; if (rx_level !== 3'd3) begin failures++; $display("FAIL full_after_pop got=%0d exp=3", rx_level); end
    tick(1);
    checks++; if (rx_level !== 3'd4) begin failures++; $display("FAIL full_fifth_in got=%0d exp=4", rx_level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_sixth_ready got=%0b exp=1", in_ready); end
    tick(1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_data !== exp[i]) begin
        failures++;
        $display("FAIL full_drain%0d got=%02h exp=%02h", i, rx_data, exp[i]);
      end
      rd = 1'b1; tick(1); rd = 1'b0; tick(1);
    end
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b exp=0", rx_full); end
  endtask

  task automatic test_start_and_prog();
    do_reset();
    send(8'h30);
    tick(1);
    checks++; if (rx_full !== 1'b1) begin failures++; $display("FAIL start_pre_fifo got=%0b exp=1", rx_full); end
    send(8'h55);
    tick(1000);
    send(8'hAA);
    checks++; if (prog_recv !== 1'b1) begin failures++; $display("FAIL start_prog_recv got=%0b exp=1", prog_recv); end
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL start_flush got=%0b exp=0", rx_full); end
    checks++; if (rx_level !== 3'd0) begin failures++; $display("FAIL start_level got=%0d exp=0", rx_level); end
    seen.delete();
    prog_ready = 1'b1;
    send(8'h01);
    send(8'h7F);
    send(8'hFF);
    checks++; if (prog_recv !== 1'b0) begin failures++; $display("FAIL prog_exit got=%0b exp=0", prog_recv); end
    checks++; if (prog_bytes !== 16'd3) begin failures++; $display("FAIL prog_bytes got=%0d exp=3", prog_bytes); end
    tick(2);
    checks++;
    if (seen.size() != 3) begin
      failures++;
      $display("FAIL prog_seen_count got=%0d exp=3", seen.size());
    end else if (seen[0] !== 8'h01 || seen[1] !== 8'h7F || seen[2] !== 8'hFF) begin
      failures++;
      $display("FAIL prog_seen_data got=%02h %02h %02h exp=01 7f ff", seen[0], seen[1], seen[2]);
    end
    checks++; if (prog_valid !== 1'b0) begin failures++; $display("FAIL prog_drained got=%0b exp=0", prog_valid); end
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL prog_no_fifo got=%0b exp=0", rx_full); end
  endtask

  task automatic test_gap_short();
    do_reset();
    send(8'h55);
    tick(50);
    send(8'hAA);
    tick(2);
    checks++; if (prog_recv !== 1'b0) begin failures++; $display("FAIL short_prog_recv got=%0b exp=0", prog_recv); end
    checks++; if (rx_level !== 3'd2) begin failures++; $display("FAIL short_level got=%0d exp=2", rx_level); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL short_head got=%02h exp=55", rx_data); end
    rd = 1'b1; tick(1); rd = 1'b0;
    checks++; if (rx_data !== 8'hAA) begin failures++; $display("FAIL short_second got=%02h exp=aa", rx_data); end
  endtask

  task automatic test_gap_timeout();
    do_reset();
    send(8'h55);
    tick(20001);
    checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL lone_early got=%0b exp=0", rx_full); end
    tick(1);
    checks++; if (rx_full !== 1'b1) begin failures++; $display("FAIL lone_release got=%0b exp=1", rx_full); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL lone_data got=%02h exp=55", rx_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    enter_prog();
    prog_ready = 1'b0;
    send(8'h5A);
    in_data  = 8'h5B;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    checks++; if (prog_data !== 8'h5A) begin failures++; $display("FAIL bp_data got=%02h exp=5a", prog_data); end
    tick(3);
    checks++; if (prog_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold got=%0b exp=1", prog_valid); end
    prog_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    tick(1);
    in_valid = 1'b0;
    checks++; if (prog_data !== 8'h5B) begin failures++; $display("FAIL bp_next_data got=%02h exp=5b", prog_data); end
    checks++; if (prog_bytes !== 16'd2) begin failures++; $display("FAIL bp_bytes got=%0d exp=2", prog_bytes); end
  endtask

  task automatic test_timeout();
    t_rst = 1'b1; tick(2); t_rst = 1'b0;
    t_in_data = 8'h55; t_in_valid = 1'b1; tick(1); t_in_valid = 1'b0;
    tick(300);
    t_in_data = 8'hAA; t_in_valid = 1'b1; tick(1); t_in_valid = 1'b0;
    checks++; if (t_prog_recv !== 1'b1) begin failures++; $display("FAIL to_enter got=%0b exp=1", t_prog_recv); end
    tick(999);
    checks++; if (t_prog_recv !== 1'b1) begin failures++; $display("FAIL to_early got=%0b exp=1", t_prog_recv); end
    tick(1);
    checks++; if (t_prog_recv !== 1'b0) begin failures++; $display("FAIL to_exit got=%0b exp=0", t_prog_recv); end
    checks++; if (t_prog_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%0b exp=1", t_prog_timeout); end
    t_rst = 1'b1; tick(1); t_rst = 1'b0;
    checks++;
    if (t_prog_timeout !== 1'b0 || t_prog_recv !== 1'b0 || t_prog_valid !== 1'b0 ||
        t_prog_bytes !== 16'd0 || t_prog_data !== 8'h00 || t_rx_full !== 1'b0 ||
        t_rx_level !== 3'd0 || t_rx_data !== 8'h00 || t_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL to_reset got=to%0b recv%0b pv%0b pb%0d pd%02h rf%0b rl%0d rd%02h ir%0b exp=0000000001",
               t_prog_timeout, t_prog_recv, t_prog_valid, t_prog_bytes, t_prog_data,
               t_rx_full, t_rx_level, t_rx_data, t_in_ready);
    end
  endtask

  task automatic test_reset_mid_prog();
    do_reset();
    enter_prog();
    prog_ready = 1'b0;
    send(8'h11);
    checks++; if (prog_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%0b exp=1", prog_valid); end
    rst = 1'b1;
    tick(1);
    checks++; if (prog_recv !== 1'b0) begin failures++; $display("FAIL mid_recv got=%0b exp=0", prog_recv); end
    checks++; if (prog_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", prog_valid); end
    checks++; if (prog_bytes !== 16'd0) begin failures++; $display("FAIL mid_bytes got=%0d exp=0", prog_bytes); end
    checks++; if (prog_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%02h exp=00", prog_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
    rst = 1'b0;
    prog_ready = 1'b1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    rd           = 1'b0;
    prog_ready   = 1'b1;
    t_rst        = 1'b1;
    t_in_data    = 8'h00;
    t_in_valid   = 1'b0;
    t_rd         = 1'b0;
    t_prog_ready = 1'b1;

    test_reset();
    test_fifo_basic();
    test_fifo_full();
    test_start_and_prog();
    test_gap_short();
    test_gap_timeout();
    test_backpressure();
    test_timeout();
    test_reset_mid_prog();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
